shared_dff_register_arbiter: RTL

- Shares one DATA_WIDTH-wide bank of D flip-flops (Q/Qb pair) between NUM_REQ requesters.
- A round-robin arbiter grants one writer per cycle. A lock option lets the winner keep the bank for multi-cycle bursts.
- Registered output and write counter are used by downstream consumers to track updates.
- Sits between requester logic and the shared storage register in flip-flop based datapaths.

---
 rtl/shared_dff_register_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shared_dff_register_arbiter.sv
// One shared DATA_WIDTH register bank written by NUM_REQ requesters through a
// round-robin arbiter, with an optional lock that lets the winner hold the bank for bursts.
module shared_dff_register_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic [NUM_REQ-1:0]            Req_In,
    input  logic [NUM_REQ-1:0]            Lock_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_In,
    output logic [NUM_REQ-1:0]            Grant_Out,
    output logic [IDX_W-1:0]              Owner_Out,
    output logic [DATA_WIDTH-1:0]         Q_Out,
    output logic [DATA_WIDTH-1:0]         Qb_Out,
    output logic                          Valid_Out,
    output logic [COUNT_WIDTH-1:0]        Write_Count_Out
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                   r_state, w_next_state;
    logic [IDX_W-1:0]         r_ptr, w_next_ptr;
    logic [IDX_W-1:0]         r_owner, w_next_owner;
    logic [NUM_REQ-1:0]       r_grant, w_next_grant;
    logic [DATA_WIDTH-1:0]    r_q, w_next_q;
    logic                     r_valid, w_next_valid;
    logic [COUNT_WIDTH-1:0]   r_count, w_next_count;

    logic                     w_found;
    logic [IDX_W-1:0]         w_win;
    logic [IDX_W-1:0]         w_ptr_after_win;
    logic [DATA_WIDTH-1:0]    w_win_data;
    logic [DATA_WIDTH-1:0]    w_own_data;

    // Scan offsets from highest to lowest so the request nearest to r_ptr wins.
    always_comb begin : arb_scan
        int               v_sum;
        logic [IDX_W-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_sum = int'(r_ptr) + k;
            if (v_sum >= NUM_REQ) begin
                v_sum = v_sum - NUM_REQ;
            end
            v_idx = IDX_W'(v_sum);
            if (Req_In[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin : ptr_wrap
        int v_next;
        v_next = int'(w_win) + 1;
        if (v_next >= NUM_REQ) begin
            v_next = 0;
        end
        w_ptr_after_win = IDX_W'(v_next);
    end

    assign w_win_data = Data_In[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_own_data = Data_In[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin : next_state_logic
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_owner = r_owner;
        w_next_grant = '0;
        w_next_q     = r_q;
        w_next_valid = 1'b0;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_grant = NUM_REQ'(1) << w_win;
                    w_next_owner = w_win;
                    w_next_q     = w_win_data;
                    w_next_valid = 1'b1;
                    w_next_count = r_count + COUNT_WIDTH'(1);
                    w_next_ptr   = w_ptr_after_win;
                    if (Lock_In[w_win]) begin
                        w_next_state = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                // Any drop of request or lock releases; the release edge itself grants nobody.
                if (Req_In[r_owner] && Lock_In[r_owner]) begin
                    w_next_grant = NUM_REQ'(1) << r_owner;
                    w_next_q     = w_own_data;
                    w_next_valid = 1'b1;
                    w_next_count = r_count + COUNT_WIDTH'(1);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_owner <= w_next_owner;
            r_grant <= w_next_grant;
            r_q     <= w_next_q;
            r_valid <= w_next_valid;
            r_count <= w_next_count;
        end
    end

    assign Grant_Out       = r_grant;
    assign Owner_Out       = r_owner;
    assign Q_Out           = r_q;
    assign Qb_Out          = ~r_q;
    assign Valid_Out       = r_valid;
    assign Write_Count_Out = r_count;

endmodule
